// File: rtl/musa_if_pkg.sv
// Shared IF-stage definitions: fetch FSM state encoding and default widths
// reused by the PC register, fetch controller and IF/ID register.
package musa_if_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_INC    = 4;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry holding register for the fetched instruction and its PC.
// Flush beats load, load beats consume.
module fetch_buffer
  import musa_if_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              consume,
  input  logic              flush,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [ADDR_W-1:0] load_pc,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc
);

  logic              valid_reg;
  logic [DATA_W-1:0] instr_reg;
  logic [ADDR_W-1:0] pc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      instr_reg <= '0;
      pc_reg    <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      instr_reg <= load_instr;
      pc_reg    <= load_pc;
    end else if (consume) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign instr = instr_reg;
  assign pc    = pc_reg;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage fetch controller: issues one outstanding instruction-memory request,
// drives PC updates, and drains requests made stale by a redirect.
module fetch_controller
  import musa_if_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int INC    = DEF_INC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pcOutput,
  output logic              pcWrite,
  output logic [ADDR_W-1:0] pcInput,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              id_ready
);

  localparam logic [ADDR_W-1:0] INC_W = ADDR_W'(INC);

  fetch_state_e      state_reg, state_next;
  logic              req_active_reg, req_active_next;
  logic [ADDR_W-1:0] req_addr_reg, req_addr_next;

  logic consume, space, start, complete;
  logic buf_load, buf_flush;

  assign consume  = instr_valid & id_ready;
  assign space    = ~instr_valid | consume;
  assign start    = ~reset & (state_reg == FETCH) & ~req_active_reg
                  & space & ~stall & ~redirect_valid;
  assign imem_req = ~reset & (req_active_reg | start);
  // A same-cycle start presents pcOutput before req_addr has captured it.
  assign imem_addr = req_active_reg ? req_addr_reg : pcOutput;
  assign complete  = imem_req & imem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= FETCH;
      req_active_reg <= 1'b0;
      req_addr_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      req_active_reg <= req_active_next;
      req_addr_reg   <= req_addr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    req_active_next = req_active_reg;
    req_addr_next   = req_addr_reg;
    pcWrite         = 1'b0;
    pcInput         = imem_addr + INC_W;
    buf_load        = 1'b0;
    buf_flush       = 1'b0;
    if (!reset) begin
      if (redirect_valid) begin
        pcWrite   = 1'b1;
        pcInput   = redirect_target;
        buf_flush = 1'b1;
        // An in-flight request cannot be withdrawn, so wait it out in DRAIN.
        if (req_active_reg && !imem_ready) begin
          state_next = DRAIN;
        end else begin
          state_next      = FETCH;
          req_active_next = 1'b0;
        end
      end else if (complete) begin
        state_next      = FETCH;
        req_active_next = 1'b0;
        if (state_reg == FETCH) begin
          pcWrite  = 1'b1;
          buf_load = 1'b1;
        end
      end else if (start) begin
        req_active_next = 1'b1;
        req_addr_next   = pcOutput;
      end
    end
  end

  fetch_buffer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load),
    .consume   (consume),
    .flush     (buf_flush),
    .load_instr(imem_rdata),
    .load_pc   (imem_addr),
    .valid     (instr_valid),
    .instr     (instr),
    .pc        (instr_pc)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller against a transaction-level model of
// the pending request, output buffer and an external PC register.
module tb_fetch_controller;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pcOutput;
  logic          pcWrite;
  logic [AW-1:0] pcInput;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready;
  logic [DW-1:0] imem_rdata;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          id_ready;

  fetch_controller #(.ADDR_W(AW), .DATA_W(DW), .INC(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .pcOutput       (pcOutput),
    .pcWrite        (pcWrite),
    .pcInput        (pcInput),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: external PC register, buffered instruction, pending request.
  logic [31:0] pc_m;
  bit          buf_v;
  logic [31:0] buf_i, buf_p;
  bit          pend, pend_stale;
  logic [31:0] pend_addr;
  bit          zero_chk;

  initial begin
    bit          e_req, e_stale, e_done, e_pw, consumed;
    logic [31:0] e_addr, e_pin;
    pc_m = 0; buf_v = 0; buf_i = 0; buf_p = 0;
    pend = 0; pend_stale = 0; pend_addr = 0; zero_chk = 0;
    reset = 1; stall = 0; redirect_valid = 0; redirect_target = 0;
    imem_ready = 0; imem_rdata = 0; id_ready = 0; pcOutput = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset = (cyc < 3) || (cyc >= 60 && $urandom_range(149) == 0);
      if (cyc < 60) begin
        imem_ready = 1; stall = 0; redirect_valid = 0; id_ready = 1;
      end else begin
        imem_ready     = ($urandom_range(1) == 0);
        stall          = ($urandom_range(4) == 0);
        redirect_valid = ($urandom_range(9) == 0);
        id_ready       = ($urandom_range(3) != 0);
      end
      if ($urandom_range(2) == 0)
        redirect_target = 32'hFFFF_FFF0 + 32'($urandom_range(3) * 4);
      else
        redirect_target = $urandom & 32'hFFFF_FFFC;
      imem_rdata = $urandom;
      pcOutput   = pc_m;
      #1;

      // Expected combinational behaviour for this cycle.
      e_req = 0; e_stale = 0; e_addr = 0; e_pw = 0; e_pin = 0;
      if (!reset) begin
        if (pend) begin
          e_req = 1; e_addr = pend_addr; e_stale = pend_stale;
        end else if (!redirect_valid && (!buf_v || id_ready) && !stall) begin
          e_req = 1; e_addr = pc_m;
        end
      end
      e_done = e_req && imem_ready;
      if (!reset) begin
        if (redirect_valid) begin
          e_pw = 1; e_pin = redirect_target;
        end else if (e_done && !e_stale) begin
          e_pw = 1; e_pin = e_addr + 32'd4;
        end
      end

      check("imem_req", imem_req, e_req);
      if (e_req) check("imem_addr", imem_addr, e_addr);
      check("pcWrite", pcWrite, e_pw);
      if (e_pw) check("pcInput", pcInput, e_pin);
      check("instr_valid", instr_valid, buf_v);
      if (buf_v || zero_chk) begin
        check("instr", instr, buf_v ? buf_i : 32'd0);
        check("instr_pc", instr_pc, buf_v ? buf_p : 32'd0);
      end

      // Advance the model to the state after this clock edge.
      zero_chk = reset;
      if (reset) begin
        buf_v = 0; buf_i = 0; buf_p = 0; pend = 0; pc_m = 0;
      end else begin
        consumed = buf_v && id_ready;
        if (e_pw) pc_m = e_pin;
        if (redirect_valid) begin
          buf_v      = 0;
          pend       = e_req && !imem_ready;
          pend_addr  = e_addr;
          pend_stale = 1;
        end else if (e_done) begin
          pend = 0;
          if (!e_stale) begin
            buf_v = 1; buf_i = imem_rdata; buf_p = e_addr;
          end else if (consumed) begin
            buf_v = 0;
          end
        end else begin
          if (consumed) buf_v = 0;
          if (e_req) begin
            pend = 1; pend_addr = e_addr; pend_stale = e_stale;
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Drives the write side of the IF-stage program counter: generates pcWrite/pcInput each cycle and fetches from instruction memory at the current PC.
- Sits between the PC register, instruction memory, the hazard/branch logic and the IF/ID boundary.
- Holds one fetched instruction in a single-entry output buffer.
- Advances the PC by INC on each accepted fetch; redirects it on branch/jump, flushing stale data.

Parameters:
- ADDR_W, 32, PC/address width
- DATA_W, 32, instruction width
- INC, 4, PC increment per fetched instruction (modulo 2^ADDR_W)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- pcOutput  input  ADDR_W  current PC value from the PC register
- pcWrite  output  1  PC load enable, combinational
- pcInput  output  ADDR_W  next PC value, combinational, meaningful only when pcWrite=1
- stall  input  1  hazard unit: do not start a new fetch
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_target  input  ADDR_W  new PC on redirect
- imem_req  output  1  instruction memory request
- imem_addr  output  ADDR_W  request address; equals the registered request address while a request is active
- imem_ready  input  1  memory completes the active request this cycle
- imem_rdata  input  DATA_W  instruction data, valid when imem_ready=1
- instr_valid  output  1  output buffer holds an instruction
- instr  output  DATA_W  buffered instruction
- instr_pc  output  ADDR_W  PC of the buffered instruction
- id_ready  input  1  decode accepts the buffer this cycle

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high; ports are named clk and reset.
- Reset, effective at the next clk edge:
  - state=FETCH, req_active=0, instr_valid=0, instr=0, instr_pc=0.
  - While reset=1: imem_req=0 and pcWrite=0, forced combinationally.
- States:
  - FETCH: normal operation.
  - DRAIN: waiting out a request that a redirect has made stale.
- Consume: when instr_valid & id_ready, the buffer frees at the clock edge.
- Buffer space (space): the buffer is empty, or it is consumed this cycle.
- Starting a request (FETCH, req_active=0):
  - Condition: space & !stall & !redirect_valid.
  - Then imem_req=1 with imem_addr=pcOutput; register req_addr=pcOutput and set req_active=1.
- Request stability: once imem_req is raised, it stays 1 with imem_addr stable (req_addr) until imem_ready. Stall does not withdraw an active request.
- Single-cycle completion: imem_ready may be 1 in the same cycle a request starts; zero-wait memory then gives one instruction per cycle.
- Completion in FETCH (imem_ready=1, no redirect):
  - Load instr=imem_rdata, instr_pc=req_addr (or pcOutput on a same-cycle start), instr_valid=1.
  - Drive pcWrite=1, pcInput=req_addr+INC, truncated to ADDR_W (wraps from all-ones to low values).
  - Clear req_active.
- Redirect (redirect_valid=1) has priority over everything except reset:
  - pcWrite=1, pcInput=redirect_target.
  - instr_valid clears at the edge, even if consumed the same cycle.
  - No new request is started this cycle.
  - If a request is active and imem_ready=0: go to DRAIN, keeping imem_req asserted.
  - If imem_ready=1 in the same cycle: the data is discarded and the state stays FETCH.
- DRAIN:
  - imem_req stays asserted at req_addr.
  - On imem_ready: discard the data, clear req_active, return to FETCH.
  - No pcWrite unless a new redirect arrives; it is then honoured and DRAIN continues.
- No fetch while the buffer is full and id_ready=0: the PC holds (pcWrite=0).
- Stall with no active request: no request, pcWrite=0, buffer unaffected.
- Output timing: instr_valid, instr and instr_pc are registered; they change only at clk edges.
- Throughput: at most one request is outstanding.

Decomposition:
- Shared package (musa_if_pkg):
  - state encoding constants FETCH and DRAIN
  - defaults for ADDR_W, DATA_W and INC, reused by the PC and IF/ID register
- One sub-module: fetch_buffer, the single-entry valid/instr/pc holding register with load/consume/flush inputs. The FSM and PC logic stay in the top.

Test Plan:
- Reset then zero-wait memory (imem_ready tied 1), pcOutput fed back from a PC model starting at 0, id_ready=1 → fetches at 0,4,8,12 on consecutive cycles; pcInput = 4,8,12,16; instr_pc matches.
- Memory with 2 wait cycles at addr 0x10 → imem_req held 3 cycles with imem_addr=0x10 stable; single pcWrite pulse with pcInput=0x14 in the ready cycle.
- Redirect to 0x100 while a request at 0x20 is waiting → pcInput=0x100 that cycle; DRAIN until ready; data for 0x20 never appears on instr; next request at 0x100.
- id_ready=0 with the buffer full → no imem_req, pcWrite=0, instr stable; raising id_ready re-enables fetch in the same cycle.
- stall=1 for 3 cycles with no request active → no imem_req, pcWrite=0; with a request active, it still completes and pcWrite pulses once.
- pcOutput=0xFFFFFFFC completes → pcInput=0x00000000; reset asserted during DRAIN → next cycle state FETCH, instr_valid=0, imem_req=0.
